instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes symbolic instruction requests (operation, register indices, immediate) and encodes them into 32-bit RV32 words for the core's supported subset.
- Writes the encoded words sequentially into instruction memory through a single write port.
- Sits between the test/boot host and instruction memory; builds a program image before the core runs.
- Validates immediates. Rejected requests raise an error and are not written.

Parameters:
ADDR_W, 8, width of the instruction-memory word address
MAX_WORDS, 256, maximum words per program (must be ≤ 2**ADDR_W)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; (re)starts a program load at base_addr
base_addr  in  ADDR_W  first word address of the program
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_op  in  4  0 ADD,1 SUB,2 SLT,3 AND,4 SLL,5 SRL,6 SRA,7 ADDI,8 LW,9 SW,10 BEQ,11 JAL,12 JALR,13 LUI,14 AUIPC,15 ADDUQB
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate (byte offset for BEQ/JAL; full value for LUI/AUIPC)
in_last  in  1  marks the final request of the program
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  word address to write
mem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since start
busy  out  1  high in ACCEPT/ENC/WR
done  out  1  high in DONE
full  out  1  high in FULL
err  out  1  one-cycle pulse when a request is rejected
err_code  out  2  01 imm out of range, 10 misaligned offset, 11 U-imm low bits nonzero; holds until next err or start

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE. All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, full, err, err_code.
- FSM states: IDLE, ACCEPT, ENC, WR, DONE, FULL.
- IDLE: start → ACCEPT; addr←base_addr, count←0, err_code←00.
- start in ACCEPT/ENC/WR/DONE/FULL: same restart. Any in-flight word is discarded (no mem_we). Reset has priority over start.
- ACCEPT: in_ready=1. On in_valid & in_ready, register all in_* fields and go to ENC.
- ENC: encode and check, taking 1 cycle.
  - Check passes → WR.
  - Check fails → err=1 for 1 cycle with err_code set; count and addr unchanged; next state ACCEPT (or DONE if the captured in_last=1).
- WR: mem_we=1 for exactly one cycle with mem_addr=addr and mem_wdata=word. Then addr+1, count+1. Next state:
  - DONE if captured in_last=1;
  - else FULL if count reaches MAX_WORDS;
  - else ACCEPT.
- Latency: handshake at cycle T → mem_we at T+2. Throughput is 1 request per 3 cycles.
- DONE/FULL: in_ready=0. Requests are ignored. Leave only on start or reset.
- addr wraps modulo 2**ADDR_W. count does not wrap; FULL prevents overflow.
- Encodings (funct7|funct3|opcode):
  - R-type, opcode 0110011, funct7 0000000: ADD f3 000, SLT 010, AND 111, SLL 001, SRL 101.
  - R-type, opcode 0110011, funct7 0100000: SUB f3 000, SRA 101.
  - ADDUQB: R-type, opcode 0001011, funct7 0, funct3 000.
  - ADDI: I-type, opcode 0010011, f3 000.
  - LW: I-type, opcode 0000011, f3 010.
  - JALR: I-type, opcode 1100111, f3 000.
  - SW: S-type, opcode 0100011, f3 010.
  - BEQ: B-type, opcode 1100011, f3 000.
  - JAL: J-type, opcode 1101111.
  - LUI: U-type, opcode 0110111.
  - AUIPC: U-type, opcode 0010111.
  - Unused fields are encoded as 0 (e.g. rs2 for I-type, rd for S/B).
- Immediate checks:
  - I/S: imm must be in [-2048, 2047], else 01.
  - B: imm must be in [-4096, 4094], else 01; imm[0] must be 0, else 10.
  - J: imm must be in [-2^20, 2^20-2], else 01; imm[0] must be 0, else 10.
  - U: imm[11:0] must be 0, else 11.
  - R: no check.
  - When range and alignment both fail, report 01.

Test Plan:
- start base_addr=0x10, then ADDI rd=1 rs1=0 imm=5 → mem_we at T+2, mem_addr=0x10, mem_wdata=0x00500093, count=1.
- SUB rd=3 rs1=1 rs2=2 → 0x402081B3. Then LW rd=5 rs1=2 imm=4 with in_last=1 → 0x00412283, then done=1 and in_ready=0.
- BEQ rs1=1 rs2=2 imm=-8 → 0xFE208CE3. JAL rd=1 imm=3 → err pulse, err_code=10, no mem_we, count unchanged.
- ADDI imm=4096 → err_code=01. LUI imm=0x00001001 → err_code=11. A following valid request is written at the unchanged address.
- MAX_WORDS=4, five back-to-back ADD requests → four writes at base..base+3, full=1, fifth request never accepted (in_ready=0). start restarts with count=0.
- reset_n low during ENC of a valid request → no mem_we, all outputs 0 next cycle, state IDLE. start mid-WR-pending (in ENC) → word discarded, count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Turns symbolic instruction requests (op, rd, rs1, rs2, imm) into 32-bit
// RV32 words for the core's supported subset. It writes them one after another
// into instruction memory through a single write port. Requests whose
// immediate cannot be encoded raise a one-cycle err pulse and are not written.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, base_addr      (re)start a program load at base_addr
//   in_valid / in_ready   request handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm, in_last   request fields
//   mem_we, mem_addr, mem_wdata                      memory write port
//   count                 words written since start
//   busy, done, full      status (ACCEPT/ENC/WR, DONE, FULL)
//   err, err_code         reject pulse and sticky reason code
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_ENC, S_WR, S_DONE, S_FULL
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_ADDI,
        OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ADDUQB
    } op_t;

    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_ULOW  = 2'b11;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    state_t              r_state;
    op_t                 r_op;
    logic [4:0]          r_rd, r_rs1, r_rs2;
    logic [31:0]         r_imm;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         r_word;
    logic                r_err;
    logic [1:0]          r_err_code;

    state_t              w_next_state;
    logic [31:0]         w_word;
    logic [1:0]          w_code;   // 00 = request is encodable
    logic signed [31:0]  w_imm_s;

    assign w_imm_s = signed'(r_imm);

    // Encoder and immediate checker, evaluated on the captured request.
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_word = '0;
        w_code = 2'b00;
        unique case (r_op)
            OP_ADD:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0110011};
            OP_SUB:    w_word = {7'b0100000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0110011};
            OP_SLT:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b010, r_rd, 7'b0110011};
            OP_AND:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b111, r_rd, 7'b0110011};
            OP_SLL:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b001, r_rd, 7'b0110011};
            OP_SRL:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b101, r_rd, 7'b0110011};
            OP_SRA:    w_word = {7'b0100000, r_rs2, r_rs1, 3'b101, r_rd, 7'b0110011};
            OP_ADDUQB: w_word = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, 7'b0001011};
            OP_ADDI, OP_LW, OP_JALR: begin
                if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) w_code = ERR_RANGE;
                case (r_op)
                    OP_ADDI: w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b0010011};
                    OP_LW:   w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, 7'b0000011};
                    default: w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b1100111};
                endcase
            end
            OP_SW: begin
                if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) w_code = ERR_RANGE;
                w_word = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], 7'b0100011};
            end
            OP_BEQ: begin
                // Range failure outranks misalignment.
                if (w_imm_s < -32'sd4096 || w_imm_s > 32'sd4094) w_code = ERR_RANGE;
                else if (r_imm[0])                                w_code = ERR_ALIGN;
                w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b000,
                          r_imm[4:1], r_imm[11], 7'b1100011};
            end
            OP_JAL: begin
                if (w_imm_s < -32'sd1048576 || w_imm_s > 32'sd1048574) w_code = ERR_RANGE;
                else if (r_imm[0])                                     w_code = ERR_ALIGN;
                w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, 7'b1101111};
            end
            OP_LUI, OP_AUIPC: begin
                if (r_imm[11:0] != 12'h000) w_code = ERR_ULOW;
                w_word = {r_imm[31:12], r_rd, (r_op == OP_LUI) ? 7'b0110111 : 7'b0010111};
            end
        endcase
    end

    // Next-state logic; start overrides everything except reset.
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_ACCEPT;
        end else begin
            case (r_state)
                S_ACCEPT: if (in_valid) w_next_state = S_ENC;
                S_ENC: begin
                    if (w_code != 2'b00) w_next_state = r_last ? S_DONE : S_ACCEPT;
                    else                 w_next_state = S_WR;
                end
                S_WR: begin
                    if (r_last)                         w_next_state = S_DONE;
                    else if (r_count + 1'b1 == MAX_CNT) w_next_state = S_FULL;
                    else                                w_next_state = S_ACCEPT;
                end
                default: w_next_state = r_state;   // IDLE, DONE, FULL wait for start
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_ADD;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_last     <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_next_state;
            r_err   <= 1'b0;
            if (start) begin
                r_addr     <= base_addr;
                r_count    <= '0;
                r_err_code <= 2'b00;
            end else begin
                case (r_state)
                    S_ACCEPT: if (in_valid) begin
                        r_op   <= op_t'(in_op);
                        r_rd   <= in_rd;
                        r_rs1  <= in_rs1;
                        r_rs2  <= in_rs2;
                        r_imm  <= in_imm;
                        r_last <= in_last;
                    end
                    S_ENC: begin
                        if (w_code != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= w_code;
                        end else begin
                            r_word <= w_word;
                        end
                    end
                    S_WR: begin
                        r_addr  <= r_addr + 1'b1;   // wraps modulo 2**ADDR_W
                        r_count <= r_count + 1'b1;  // bounded by FULL
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = (r_state == S_ACCEPT);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign count     = r_count;
    assign busy      = (r_state == S_ACCEPT) || (r_state == S_ENC) || (r_state == S_WR);
    assign done      = (r_state == S_DONE);
    assign full      = (r_state == S_FULL);
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
